cdc_hs_tx_mc: RTL and testbench
===============================

Name: cdc_hs_tx_mc

Overview:
- Source-side controller for a multi-channel CDC handshake.
- Arbitrates round-robin among G_CHANNELS local producers and captures the winner's word into a held-stable data register.
- Drives a request to the remote domain in either 4-phase (level) or 2-phase (toggle) mode, and synchronises the returning acknowledge internally.
- Adds a watchdog timeout flag.
- Runs entirely in the source clock domain; the remote responder is a separate block.

Parameters:
- G_STAGES, 2: synchroniser depth on i_ack (>=2).
- G_WIDTH, 8: data word width.
- G_CHANNELS, 4: number of producer channels (>=1).
- G_MODE, 0: 0 = 4-phase level handshake; 1 = 2-phase toggle handshake.
- G_TIMEOUT, 1023: cycles allowed in a wait state before o_timeout sets; 0 disables the watchdog.
- G_CH_W, derived: max(1, clog2(G_CHANNELS)).

Ports:
- i_clk  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  G_CHANNELS  per-channel word-available.
- i_data  in  G_CHANNELS*G_WIDTH  channel k occupies bits [k*G_WIDTH +: G_WIDTH].
- o_ready  out  G_CHANNELS  one-cycle pulse: channel word captured.
- o_req  out  1  request to remote domain (registered, glitch-free).
- o_data  out  G_WIDTH  captured word, stable while o_busy=1.
- o_chan  out  G_CH_W  channel index of the captured word.
- i_ack  in  1  asynchronous acknowledge from remote domain.
- o_busy  out  1  transfer in flight.
- o_done  out  1  one-cycle pulse: transfer completed.
- o_timeout  out  1  sticky watchdog error.

Behaviour:
- One clock (i_clk). Reset (i_rst) is synchronous and active-high.
- Reset values: state=IDLE, o_req=0, o_data=0, o_chan=0, o_ready=0, o_busy=0, o_done=0, o_timeout=0, sync flops=0, rr pointer=G_CHANNELS-1 (so ch0 has first priority), watchdog=0.
- ack_s: i_ack through G_STAGES flops. FSM uses only ack_s. Ack-to-FSM latency is G_STAGES cycles.
- All outputs are registered. o_ready and o_done default to 0 every cycle.
- IDLE:
  - If any i_valid, grant channel k = first valid found searching from ptr+1 upward, wrapping modulo G_CHANNELS.
  - At that edge: o_data<=i_data[k], o_chan<=k, ptr<=k, o_ready[k]<=1, o_busy<=1, state<=REQ.
  - o_req<=1 if G_MODE=0; o_req<=~o_req if G_MODE=1.
  - No valid: hold.
- REQ:
  - G_MODE=0: when ack_s=1, o_req<=0, state<=REL.
  - G_MODE=1: when ack_s==o_req, o_busy<=0, o_done<=1, state<=IDLE.
- REL (G_MODE=0 only): when ack_s=0, o_busy<=0, o_done<=1, state<=IDLE.
- Illegal state encoding: return to IDLE.
- Producer rule: hold i_valid and i_data until o_ready[k] is sampled high; advance or drop i_valid on that edge. o_busy blocks any re-grant before then.
- o_data and o_chan change only on a capture edge. The remote side may sample o_data any time after seeing req.
- Back-to-back: at least one IDLE cycle between o_done and the next capture edge. The next grant can occur on the edge after o_done is set.
- Fairness: with all channels valid continuously, grant order is 0,1,2,3,0,...
- Watchdog:
  - Counter clears on entry to REQ or REL and increments each cycle in REQ/REL.
  - At count == G_TIMEOUT, o_timeout<=1; it stays set until i_rst and the counter saturates.
  - The transfer is not aborted; the FSM keeps waiting.
- 2-phase mode: o_req level alternates per transfer; after reset the first transfer drives o_req 0->1.
- Reset mid-transfer: everything returns to reset values the next edge and any captured word is lost. The remote responder must be reset in the same reset event.
- G_CHANNELS=1: o_chan is constant 0 and arbitration is trivial.

Test Plan:
- G_MODE=0, ch2 valid with data 0xA5; remote echoes req after 3 cycles -> o_ready=0b0100 one cycle after grant, o_chan=2, o_data=0xA5 stable until o_done, o_req high then low, one o_done pulse, o_busy falls with o_done.
- All 4 channels valid with data 0x10..0x13, 8 transfers -> o_chan sequence 0,1,2,3,0,1,2,3; exactly one o_ready bit per transfer.
- G_MODE=1, 3 transfers with remote toggling ack -> o_req levels 1,0,1 across the transfers, no REL state, o_done count=3.
- G_TIMEOUT=16, i_ack held 0 -> o_timeout rises exactly 16 cycles after REQ entry and stays high. Then release ack -> transfer completes and o_timeout remains 1 until i_rst.
- Assert i_rst while in REL with o_req=0 and ack_s=1 -> next edge all outputs zero, state IDLE; first transfer after reset grants ch0 (ptr reset value).
- i_ack pulse shorter than G_STAGES cycles while in IDLE -> no state change, o_req stays 0, no o_done.

Source files
------------

// File: rtl/cdc_hs_tx_mc.sv
// Source side of a multi-channel CDC handshake: round-robin grant, held data register, level or toggle request.
// Latency: capture one edge after a grant; acknowledge reaches the FSM G_STAGES edges after i_ack changes.
// Backpressure: a producer holds i_valid/i_data until its o_ready pulse; o_busy blocks any re-grant until o_done.
module cdc_hs_tx_mc #(
   parameter int G_STAGES   = 2,
   parameter int G_WIDTH    = 8,
   parameter int G_CHANNELS = 4,
   parameter int G_MODE     = 0,
   parameter int G_TIMEOUT  = 1023,
   localparam int G_CH_W    = (G_CHANNELS > 1) ? $clog2(G_CHANNELS) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [G_CHANNELS-1:0]         i_valid,
   input  logic [G_CHANNELS*G_WIDTH-1:0] i_data,
   output logic [G_CHANNELS-1:0]         o_ready,
   output logic                          o_req,
   output logic [G_WIDTH-1:0]            o_data,
   output logic [G_CH_W-1:0]             o_chan,
   input  logic                          i_ack,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_timeout
);

   localparam int WD_W = (G_TIMEOUT > 0) ? $clog2(G_TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(G_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(G_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [G_STAGES-1:0]   sync_q, sync_d;
   logic                  ack_s;
   logic [G_CH_W-1:0]     ptr_q, ptr_d;
   logic [G_CH_W-1:0]     chan_q, chan_d;
   logic [G_WIDTH-1:0]    data_q, data_d;
   logic [G_CHANNELS-1:0] ready_q, ready_d;
   logic                  req_q, req_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timeout_q, timeout_d;
   logic [WD_W-1:0]       wd_q, wd_d;

   logic                  grant_vld;
   logic [G_CH_W-1:0]     grant_idx;
   logic [G_WIDTH-1:0]    grant_dat;
   int                    cand;

   // acknowledge synchroniser: the FSM only ever looks at the last stage
   always_comb begin
      sync_d = {sync_q[G_STAGES-2:0], i_ack};
   end

   assign ack_s = sync_q[G_STAGES-1];

   // round-robin search starting just after the last granted channel
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      grant_dat = '0;
      cand      = 0;
      for (int i = 1; i <= G_CHANNELS; i++) begin
         cand = (int'(ptr_q) + i) % G_CHANNELS;
         for (int k = 0; k < G_CHANNELS; k++) begin
            if (!grant_vld && (k == cand) && i_valid[k]) begin
               grant_vld = 1'b1;
               grant_idx = G_CH_W'(k);
               grant_dat = i_data[k*G_WIDTH +: G_WIDTH];
            end
         end
      end
   end

   // handshake FSM next state, registered outputs and watchdog
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      chan_d    = chan_q;
      data_d    = data_q;
      ready_d   = '0;
      req_d     = req_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      wd_d      = wd_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               data_d  = grant_dat;
               chan_d  = grant_idx;
               ptr_d   = grant_idx;
               ready_d = G_CHANNELS'(1) << grant_idx;
               busy_d  = 1'b1;
               req_d   = (G_MODE == 0) ? 1'b1 : ~req_q;
               wd_d    = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (G_MODE == 0) begin
               if (ack_s) begin
                  req_d   = 1'b0;
                  wd_d    = '0;
                  state_d = ST_REL;
               end
            end else if (ack_s == req_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_REL: begin
            if (!ack_s) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // watchdog counts waiting cycles, saturates, and never aborts the transfer
      if ((G_TIMEOUT > 0) && ((state_q == ST_REQ) || (state_q == ST_REL))) begin
         if (wd_q == WD_LAST) begin
            timeout_d = 1'b1;
         end
         if ((state_d == state_q) && (wd_q != WD_MAX)) begin
            wd_d = wd_q + 1'b1;
         end
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         sync_q    <= '0;
         ptr_q     <= G_CH_W'(G_CHANNELS - 1);
         chan_q    <= '0;
         data_q    <= '0;
         ready_q   <= '0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         wd_q      <= '0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         ptr_q     <= ptr_d;
         chan_q    <= chan_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         req_q     <= req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         wd_q      <= wd_d;
      end
   end

   assign o_ready   = ready_q;
   assign o_req     = req_q;
   assign o_data    = data_q;
   assign o_chan    = chan_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_timeout = timeout_q;

endmodule

// File: tb/tb_cdc_hs_tx_mc.sv
// Bench for cdc_hs_tx_mc: a 4-phase and a 2-phase instance share stimulus through a select.
// Producers are word queues, the remote side is a delayed follower of o_req.
// Every check goes through chk(); one summary line at the end.
module tb_cdc_hs_tx_mc;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;

   logic core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   logic             rst;
   logic             sel;
   logic [N-1:0]     valid;
   logic [N*W-1:0]   data;
   logic             ack;

   logic [N-1:0] valid0, valid1, ready0, ready1;
   logic         ack0, ack1, req0, req1, busy0, busy1, done0, done1, to0, to1;
   logic [W-1:0] dat0, dat1;
   logic [1:0]   ch0, ch1;

   logic [N-1:0] o_ready;
   logic         o_req, o_busy, o_done, o_timeout;
   logic [W-1:0] o_data;
   logic [1:0]   o_chan;

   assign valid0 = sel ? '0 : valid;
   assign valid1 = sel ? valid : '0;
   assign ack0   = sel ? 1'b0 : ack;
   assign ack1   = sel ? ack : 1'b0;

   assign o_ready   = sel ? ready1 : ready0;
   assign o_req     = sel ? req1   : req0;
   assign o_busy    = sel ? busy1  : busy0;
   assign o_done    = sel ? done1  : done0;
   assign o_timeout = sel ? to1    : to0;
   assign o_data    = sel ? dat1   : dat0;
   assign o_chan    = sel ? ch1    : ch0;

   cdc_hs_tx_mc #(.G_STAGES(2), .G_WIDTH(W), .G_CHANNELS(N), .G_MODE(0), .G_TIMEOUT(TO)) u_dut_4p (
      .i_clk(core_clk), .i_rst(rst), .i_valid(valid0), .i_data(data), .o_ready(ready0),
      .o_req(req0), .o_data(dat0), .o_chan(ch0), .i_ack(ack0), .o_busy(busy0),
      .o_done(done0), .o_timeout(to0));

   cdc_hs_tx_mc #(.G_STAGES(2), .G_WIDTH(W), .G_CHANNELS(N), .G_MODE(1), .G_TIMEOUT(TO)) u_dut_2p (
      .i_clk(core_clk), .i_rst(rst), .i_valid(valid1), .i_data(data), .o_ready(ready1),
      .o_req(req1), .o_data(dat1), .o_chan(ch1), .i_ack(ack1), .o_busy(busy1),
      .o_done(done1), .o_timeout(to1));

   // reference model state
   logic [W-1:0] pw [N][16];
   int           ph [N];
   int           pt [N];
   int           ptr_m;
   int           xfer_m;
   int           chan_log[$];
   logic         req_log[$];

   int n_pass = 0;
   int n_chk  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   function automatic int rr_pick(input logic [N-1:0] m, input int p);
      for (int i = 1; i <= N; i++) begin
         if (m[(p + i) % N]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic drive_prod();
      for (int k = 0; k < N; k++) begin
         valid[k] = (ph[k] < pt[k]);
         data[k*W +: W] = (ph[k] < pt[k]) ? pw[k][ph[k]] : '0;
      end
   endtask

   task automatic push(input int k, input logic [W-1:0] v);
      pw[k][pt[k]] = v;
      pt[k]++;
   endtask

   task automatic model_reset();
      ptr_m  = N - 1;
      xfer_m = 0;
      for (int k = 0; k < N; k++) begin
         ph[k] = 0;
         pt[k] = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge core_clk);
      rst   = 1'b1;
      valid = '0;
      ack   = 1'b0;
      @(negedge core_clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_ready"}, 32'(o_ready), 0);
      chk({pfx, "_req"}, 32'(o_req), 0);
      chk({pfx, "_data"}, 32'(o_data), 0);
      chk({pfx, "_chan"}, 32'(o_chan), 0);
      chk({pfx, "_busy"}, 32'(o_busy), 0);
      chk({pfx, "_done"}, 32'(o_done), 0);
      chk({pfx, "_timeout"}, 32'(o_timeout), 0);
   endtask

   // what: 0 = any o_ready, 1 = o_req low, 2 = o_done
   task automatic wait_for(input int what, input string tag);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge core_clk);
         ok = (what == 0) ? (o_ready != '0) : (what == 1) ? !o_req : o_done;
      end
      chk(tag, 32'(ok), 1);
   endtask

   task automatic run_traffic(input int n, input int dmin, input int dmax);
      int           done_cnt, cyc, dly, k;
      logic [W-1:0] cur;
      logic         prev_busy;
      done_cnt = 0;
      cyc      = 0;
      chan_log.delete();
      req_log.delete();
      drive_prod();
      dly       = $urandom_range(dmax, dmin);
      prev_busy = o_busy;
      cur       = o_data;
      while (done_cnt < n && cyc < 3000) begin
         @(negedge core_clk);
         cyc++;
         if (o_ready != '0) begin
            k = rr_pick(valid, ptr_m);
            if (k < 0) begin
               chk("spurious_ready", 32'(o_ready), 0);
            end else begin
               chk("ready_onehot", 32'(o_ready), 32'(1) << k);
               chk("chan", 32'(o_chan), 32'(k));
               chk("data", 32'(o_data), 32'(pw[k][ph[k]]));
               chk("busy_rise", 32'(o_busy), 1);
               chk("no_regrant", 32'(prev_busy), 0);
               xfer_m++;
               chk("req_level", 32'(o_req), sel ? 32'(xfer_m % 2) : 32'd1);
               chan_log.push_back(k);
               req_log.push_back(o_req);
               ph[k]++;
               ptr_m = k;
               cur   = o_data;
            end
         end
         if (o_done) begin
            chk("done_busy", 32'(o_busy), 0);
            chk("data_hold", 32'(o_data), 32'(cur));
            if (!sel) chk("req_released", 32'(o_req), 0);
            done_cnt++;
         end
         prev_busy = o_busy;
         if (ack !== o_req) begin
            if (dly == 0) begin
               ack = o_req;
               dly = $urandom_range(dmax, dmin);
            end else begin
               dly--;
            end
         end
         drive_prod();
      end
      chk("xfer_count", 32'(done_cnt), 32'(n));
      chk("wd_quiet", 32'(o_timeout), 0);
   endtask

   initial begin
      int total;
      rst   = 1'b1;
      sel   = 1'b0;
      valid = '0;
      data  = '0;
      ack   = 1'b0;
      do_reset();

      // reset state of both instances
      sel = 1'b0; chk_zero("rst4p");
      sel = 1'b1; chk_zero("rst2p");

      // single transfer on channel 2, remote answers after 3 cycles
      sel = 1'b0;
      do_reset();
      push(2, 8'hA5);
      run_traffic(1, 3, 3);
      chk("t1_chan", 32'(chan_log[0]), 2);

      // all channels continuously valid: strict 0,1,2,3 rotation
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N; k++) push(k, 8'(8'h10 + k));
      run_traffic(8, 0, 2);
      for (int i = 0; i < 8; i++) chk("rr_order", 32'(chan_log[i]), 32'(i % 4));

      // toggle mode: request level alternates 1,0,1
      sel = 1'b1;
      do_reset();
      push(0, 8'($urandom));
      push(1, 8'($urandom));
      push(3, 8'($urandom));
      run_traffic(3, 0, 3);
      for (int i = 0; i < 3; i++) chk("toggle_level", 32'(req_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

      // randomized traffic for both modes
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         do_reset();
         for (int r = 0; r < 3; r++) begin
            total = 0;
            for (int k = 0; k < N; k++) begin
               int cnt;
               cnt = $urandom_range(3, 0);
               for (int j = 0; j < cnt; j++) push(k, 8'($urandom));
               total += cnt;
            end
            if (total == 0) begin
               push(int'($urandom_range(N - 1, 0)), 8'($urandom));
               total = 1;
            end
            run_traffic(total, 0, 5);
         end
      end

      // watchdog: ack held low, flag rises 16 cycles after REQ entry and is sticky
      sel = 1'b0;
      do_reset();
      push(1, 8'h3C);
      drive_prod();
      wait_for(0, "wd_grant");
      ph[1]++;
      drive_prod();
      for (int i = 1; i <= 20; i++) begin
         @(negedge core_clk);
         if (i == 15) chk("wd_early", 32'(o_timeout), 0);
         if (i == 16) chk("wd_rise", 32'(o_timeout), 1);
         if (i == 20) chk("wd_hold", 32'(o_timeout), 1);
      end
      chk("wd_still_busy", 32'(o_busy), 1);
      ack = 1'b1;
      wait_for(1, "wd_req_drop");
      ack = 1'b0;
      wait_for(2, "wd_done");
      chk("wd_sticky", 32'(o_timeout), 1);
      do_reset();
      chk("wd_cleared", 32'(o_timeout), 0);

      // reset while in REL with req low and synchronised ack high
      push(1, 8'h5A);
      drive_prod();
      wait_for(0, "rel_grant");
      ph[1]++;
      drive_prod();
      ack = 1'b1;
      wait_for(1, "rel_entry");
      chk("rel_busy", 32'(o_busy), 1);
      rst = 1'b1;
      @(negedge core_clk);
      chk_zero("rst_rel");
      rst = 1'b0;
      ack = 1'b0;
      model_reset();
      for (int k = 0; k < N; k++) push(k, 8'(8'h20 + k));
      run_traffic(4, 0, 2);
      chk("post_rst_first", 32'(chan_log[0]), 0);

      // short ack glitch while idle changes nothing
      do_reset();
      ack = 1'b1;
      @(negedge core_clk);
      ack = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge core_clk);
         chk("glitch_req", 32'(o_req), 0);
         chk("glitch_done", 32'(o_done), 0);
         chk("glitch_busy", 32'(o_busy), 0);
      end
      push(3, 8'hC3);
      run_traffic(1, 1, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
